// File: rtl/spectrum_peak_finder.sv
// Per-frame peak search over FFT magnitude bins, reported one cycle after eop.
// Input stream is never stalled; back-to-back frames are supported.
//
// state   | meaning
// IDLE    | waiting for bin 0 of a new frame
// SEARCH  | frame in progress, bins counted and searched
// OVERRUN | frame ran past FFT_LEN bins, samples dropped until eop
module spectrum_peak_finder #(
    parameter int FFT_LEN = 1024,
    parameter int BIN_W   = 10,
    parameter int MAG_W   = 32,
    parameter int MIN_BIN = 1,
    parameter int MAX_BIN = 511
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MAG_W-1:0] mag_data,
    input  logic             mag_valid,
    input  logic             mag_eop,
    input  logic [MAG_W-1:0] thr,
    output logic             peak_valid,
    output logic [BIN_W-1:0] peak_bin,
    output logic [MAG_W-1:0] peak_mag,
    output logic             peak_above_thr,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_LEN - 1);
    localparam logic [BIN_W-1:0] LO_BIN   = BIN_W'(MIN_BIN);
    localparam logic [BIN_W-1:0] HI_BIN   = BIN_W'(MAX_BIN);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        OVERRUN = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [BIN_W-1:0] bin_idx;
    logic [MAG_W-1:0] max_mag;
    logic [BIN_W-1:0] max_bin;
    logic             max_seen;

    logic             report;
    logic             err_nxt;
    logic             in_window;
    logic             take;
    logic [MAG_W-1:0] cur_mag;
    logic [BIN_W-1:0] cur_bin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        report    = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mag_valid) begin
                    if (mag_eop) begin
                        report    = 1'b1;
                        err_nxt   = (bin_idx != LAST_BIN);
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (mag_valid) begin
                    if (mag_eop) begin
                        report    = 1'b1;
                        err_nxt   = (bin_idx != LAST_BIN);
                        state_nxt = IDLE;
                    end else if (bin_idx == LAST_BIN) begin
                        state_nxt = OVERRUN;
                    end
                end
            end
            OVERRUN: begin
                if (mag_valid && mag_eop) begin
                    report    = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // max_seen lets a zero-valued first candidate claim its bin over the 0/0 seed
    always_comb begin
        in_window = (bin_idx >= LO_BIN) && (bin_idx <= HI_BIN);
        take      = mag_valid && (state != OVERRUN) && in_window &&
                    (!max_seen || (mag_data > max_mag));
        cur_mag   = take ? mag_data : max_mag;
        cur_bin   = take ? bin_idx  : max_bin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_idx        <= '0;
            max_mag        <= '0;
            max_bin        <= '0;
            max_seen       <= 1'b0;
            peak_valid     <= 1'b0;
            peak_bin       <= '0;
            peak_mag       <= '0;
            peak_above_thr <= 1'b0;
            frame_err      <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            peak_valid <= report;

            if (mag_valid) begin
                bin_idx <= mag_eop ? '0 : bin_idx + BIN_W'(1);
            end

            // Reseed on the eop cycle so the next cycle can carry bin 0
            if (mag_valid && mag_eop) begin
                max_mag  <= '0;
                max_bin  <= '0;
                max_seen <= 1'b0;
            end else if (take) begin
                max_mag  <= mag_data;
                max_bin  <= bin_idx;
                max_seen <= 1'b1;
            end

            if (report) begin
                peak_mag       <= cur_mag;
                peak_bin       <= cur_bin;
                peak_above_thr <= (cur_mag >= thr);
                frame_err      <= err_nxt;
                frame_cnt      <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Directed bench for spectrum_peak_finder: reset, search window, ties, threshold,
// frame length errors and back-to-back streaming.
module tb_spectrum_peak_finder;

    localparam int BIN_W = 10;
    localparam int MAG_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [MAG_W-1:0] mag_data;
    logic             mag_valid;
    logic             mag_eop;
    logic [MAG_W-1:0] thr;
    logic             peak_valid;
    logic [BIN_W-1:0] peak_bin;
    logic [MAG_W-1:0] peak_mag;
    logic             peak_above_thr;
    logic             frame_err;
    logic [15:0]      frame_cnt;

    int          checks    = 0;
    int          failures  = 0;
    int          pulse_cnt = 0;
    logic [15:0] exp_cnt   = 16'd0;

    spectrum_peak_finder dut (
        .clk            (clk),
        .rst            (rst),
        .mag_data       (mag_data),
        .mag_valid      (mag_valid),
        .mag_eop        (mag_eop),
        .thr            (thr),
        .peak_valid     (peak_valid),
        .peak_bin       (peak_bin),
        .peak_mag       (peak_mag),
        .peak_above_thr (peak_above_thr),
        .frame_err      (frame_err),
        .frame_cnt      (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (peak_valid === 1'b1) pulse_cnt++;

    function automatic logic [31:0] pattern(input int kind, input int i);
        case (kind)
            0: begin
                if (i == 37) return 32'h00FF_0000;
                else if (i <= 100) return 32'(1000 * i);
                else return 32'd5;
            end
            1: begin
                if (i == 0 || i == 600) return 32'hFFFF_FFFF;
                else if (i == 20 || i == 40) return 32'h100;
                else return 32'd0;
            end
            2: return (i == 300) ? 32'h0000_ABCD : 32'(i & 15);
            3: return (i == 511) ? 32'h1234_5678 : 32'(i);
            4: begin
                if (i == 0 || i == 512) return 32'hFFFF_FFFF;
                else if (i == 1) return 32'd7;
                else return 32'd0;
            end
            5: begin
                if (i == 200) return 32'h0000_5000;
                else if (i >= 1024) return 32'hFFFF_FFFF;
                else return 32'd3;
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic send(input logic [31:0] d, input logic e);
        mag_data  = d;
        mag_valid = 1'b1;
        mag_eop   = e;
        @(posedge clk);
        #1;
        mag_valid = 1'b0;
        mag_eop   = 1'b0;
    endtask

    task automatic idle_cycle(input logic stray_eop);
        mag_valid = 1'b0;
        mag_eop   = stray_eop;
        mag_data  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        mag_eop   = 1'b0;
    endtask

    task automatic run_frame(input int kind, input int len, input logic with_eop, input logic gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) idle_cycle(1'($urandom_range(0, 1)));
            send(pattern(kind, i), with_eop && (i == len - 1));
        end
    endtask

    task automatic test_reset();
        int p0;
        rst = 1'b1; mag_valid = 1'b0; mag_eop = 1'b0; mag_data = '0; thr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({peak_valid, peak_bin, peak_mag, peak_above_thr, frame_err, frame_cnt} !== '0) begin failures++; $display("FAIL reset_outputs got bin=%0d mag=%h cnt=%0d exp all zero", peak_bin, peak_mag, frame_cnt); end
        rst = 1'b0;
        idle_cycle(1'b0);
        thr = 32'h1000;
        run_frame(0, 1024, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if (peak_bin !== 10'd37 || peak_mag !== 32'h00FF_0000) begin failures++; $display("FAIL pre_reset_peak got bin=%0d mag=%h exp bin=37 mag=00ff0000", peak_bin, peak_mag); end
        checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL pre_reset_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
        run_frame(0, 300, 1'b0, 1'b0);
        p0 = pulse_cnt;
        #2 rst = 1'b1;
        #1;
        checks++; if ({peak_valid, peak_bin, peak_mag, peak_above_thr, frame_err, frame_cnt} !== '0) begin failures++; $display("FAIL async_reset got bin=%0d mag=%h cnt=%0d above=%b exp all zero", peak_bin, peak_mag, frame_cnt, peak_above_thr); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_cnt = 16'd0;
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL reset_no_pulse got=%0d exp=%0d", pulse_cnt, p0); end
        run_frame(0, 1024, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if (peak_valid !== 1'b1 || peak_bin !== 10'd37 || frame_err !== 1'b0) begin failures++; $display("FAIL post_reset_frame got v=%b bin=%0d err=%b exp v=1 bin=37 err=0", peak_valid, peak_bin, frame_err); end
        checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL post_reset_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
    endtask

    task automatic test_single_tone();
        thr = 32'h00FF_0000;
        run_frame(0, 1024, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if (peak_valid !== 1'b1) begin failures++; $display("FAIL tone_valid got=%b exp=1", peak_valid); end
        checks++; if (peak_bin !== 10'd37 || peak_mag !== 32'h00FF_0000) begin failures++; $display("FAIL tone_peak got bin=%0d mag=%h exp bin=37 mag=00ff0000", peak_bin, peak_mag); end
        checks++; if (peak_above_thr !== 1'b1 || frame_err !== 1'b0) begin failures++; $display("FAIL tone_flags got above=%b err=%b exp above=1 err=0", peak_above_thr, frame_err); end
        idle_cycle(1'b0);
        checks++; if (peak_valid !== 1'b0 || peak_bin !== 10'd37 || peak_mag !== 32'h00FF_0000) begin failures++; $display("FAIL tone_hold got v=%b bin=%0d mag=%h exp v=0 bin=37 mag=00ff0000", peak_valid, peak_bin, peak_mag); end
    endtask

    task automatic test_threshold();
        thr = 32'h00FF_0001;
        run_frame(0, 1024, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if (peak_above_thr !== 1'b0) begin failures++; $display("FAIL thr_above got=%b exp=0", peak_above_thr); end
        checks++; if (peak_bin !== 10'd37 || frame_cnt !== exp_cnt) begin failures++; $display("FAIL thr_frame got bin=%0d cnt=%0d exp bin=37 cnt=%0d", peak_bin, frame_cnt, exp_cnt); end
    endtask

    task automatic test_window_ties();
        thr = 32'h0;
        run_frame(1, 1024, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if (peak_bin !== 10'd20 || peak_mag !== 32'h100) begin failures++; $display("FAIL window_tie got bin=%0d mag=%h exp bin=20 mag=100", peak_bin, peak_mag); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL window_err got=%b exp=0", frame_err); end
        run_frame(4, 1024, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if (peak_bin !== 10'd1 || peak_mag !== 32'd7) begin failures++; $display("FAIL window_edges got bin=%0d mag=%h exp bin=1 mag=7", peak_bin, peak_mag); end
        run_frame(6, 1024, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if (peak_bin !== 10'd1 || peak_mag !== 32'd0 || peak_above_thr !== 1'b1) begin failures++; $display("FAIL zero_frame got bin=%0d mag=%h above=%b exp bin=1 mag=0 above=1", peak_bin, peak_mag, peak_above_thr); end
    endtask

    task automatic test_length_errors();
        thr = 32'h0;
        run_frame(0, 500, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if (peak_valid !== 1'b1 || frame_err !== 1'b1) begin failures++; $display("FAIL short_report got v=%b err=%b exp v=1 err=1", peak_valid, frame_err); end
        checks++; if (peak_bin !== 10'd37 || peak_mag !== 32'h00FF_0000) begin failures++; $display("FAIL short_peak got bin=%0d mag=%h exp bin=37 mag=00ff0000", peak_bin, peak_mag); end
        idle_cycle(1'b0);
        checks++; if (peak_valid !== 1'b0) begin failures++; $display("FAIL short_pulse_width got=%b exp=0", peak_valid); end
        run_frame(5, 1100, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if (peak_bin !== 10'd200 || peak_mag !== 32'h5000 || frame_err !== 1'b1) begin failures++; $display("FAIL overrun got bin=%0d mag=%h err=%b exp bin=200 mag=5000 err=1", peak_bin, peak_mag, frame_err); end
        checks++; if (frame_cnt !== exp_cnt) begin failures++; $display("FAIL overrun_cnt got=%0d exp=%0d", frame_cnt, exp_cnt); end
        send(32'd9, 1'b1);
        exp_cnt++;
        checks++; if (peak_valid !== 1'b1 || peak_bin !== 10'd0 || peak_mag !== 32'd0 || frame_err !== 1'b1) begin failures++; $display("FAIL len1 got v=%b bin=%0d mag=%h err=%b exp v=1 bin=0 mag=0 err=1", peak_valid, peak_bin, peak_mag, frame_err); end
        run_frame(0, 1024, 1'b1, 1'b0);
        exp_cnt++;
        checks++; if (frame_err !== 1'b0 || peak_bin !== 10'd37) begin failures++; $display("FAIL recover_after_err got err=%b bin=%0d exp err=0 bin=37", frame_err, peak_bin); end
    endtask

    task automatic test_back_to_back();
        int p0;
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        exp_cnt = 16'd0;
        idle_cycle(1'b0);
        thr = 32'h0;
        p0 = pulse_cnt;
        run_frame(3, 1024, 1'b1, 1'b0);
        checks++; if (peak_bin !== 10'd511 || peak_mag !== 32'h1234_5678 || frame_err !== 1'b0) begin failures++; $display("FAIL b2b_f1 got bin=%0d mag=%h err=%b exp bin=511 mag=12345678 err=0", peak_bin, peak_mag, frame_err); end
        run_frame(2, 1024, 1'b1, 1'b1);
        checks++; if (peak_bin !== 10'd300 || peak_mag !== 32'hABCD || frame_err !== 1'b0) begin failures++; $display("FAIL b2b_f2 got bin=%0d mag=%h err=%b exp bin=300 mag=abcd err=0", peak_bin, peak_mag, frame_err); end
        run_frame(4, 1024, 1'b1, 1'b0);
        checks++; if (peak_bin !== 10'd1 || peak_mag !== 32'd7 || frame_err !== 1'b0) begin failures++; $display("FAIL b2b_f3 got bin=%0d mag=%h err=%b exp bin=1 mag=7 err=0", peak_bin, peak_mag, frame_err); end
        checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL b2b_cnt got=%0d exp=3", frame_cnt); end
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        checks++; if (pulse_cnt - p0 !== 3) begin failures++; $display("FAIL b2b_pulses got=%0d exp=3", pulse_cnt - p0); end
    endtask

    initial begin
        test_reset();
        test_single_tone();
        test_threshold();
        test_window_ties();
        test_length_errors();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
